// File: rtl/load_store_unit.sv
// Load/store unit: decodes a memory op, issues one aligned data-memory access,
// extends load results and flags misalignment or ack timeout with a done pulse.
module load_store_unit #(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [3:0]  i_mem_op,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_store_data,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_load_data,
   output logic        o_addr_err,
   output logic        o_bus_err,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [3:0]  o_dmem_be,
   output logic [31:0] o_dmem_wdata,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_FINISH} state_t;

   state_t      r_state;
   logic [7:0]  r_wait;
   logic        r_is_load;
   logic        r_sext;
   logic [1:0]  r_size;
   logic [1:0]  r_addr_lo;
   logic        r_addr_err_pend;
   logic        r_bus_err_pend;

   logic        w_is_load;
   logic        w_is_store;
   logic        w_sext;
   logic [1:0]  w_size;
   logic        w_misalign;
   logic        w_legal;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_lane;
   logic [31:0] w_load_ext;
   logic [7:0]  w_wait_nxt;

   // Decode the incoming request into direction, size and lane pattern
   always_comb begin
      w_is_load  = 1'b0;
      w_is_store = 1'b0;
      w_sext     = 1'b0;
      w_size     = SZ_B;
      case (i_mem_op)
         OP_LB:   begin w_is_load  = 1'b1; w_sext = 1'b1; w_size = SZ_B; end
         OP_LBU:  begin w_is_load  = 1'b1;                w_size = SZ_B; end
         OP_LH:   begin w_is_load  = 1'b1; w_sext = 1'b1; w_size = SZ_H; end
         OP_LHU:  begin w_is_load  = 1'b1;                w_size = SZ_H; end
         OP_LW:   begin w_is_load  = 1'b1;                w_size = SZ_W; end
         OP_SB:   begin w_is_store = 1'b1;                w_size = SZ_B; end
         OP_SH:   begin w_is_store = 1'b1;                w_size = SZ_H; end
         OP_SW:   begin w_is_store = 1'b1;                w_size = SZ_W; end
         default: ;
      endcase

      w_misalign = ((w_size == SZ_H) && i_addr[0]) ||
                   ((w_size == SZ_W) && (i_addr[1:0] != 2'b00));
      w_legal    = (w_is_load || w_is_store) && !w_misalign;

      case (w_size)
         SZ_B:    begin w_be = 4'b0001 << i_addr[1:0]; w_wdata = {4{i_store_data[7:0]}};  end
         SZ_H:    begin w_be = 4'b0011 << i_addr[1:0]; w_wdata = {2{i_store_data[15:0]}}; end
         default: begin w_be = 4'b1111;                w_wdata = i_store_data;            end
      endcase
   end

   // Shift the addressed lane down to bit 0 and extend it
   always_comb begin
      w_lane = i_dmem_rdata >> {r_addr_lo, 3'b000};
      case (r_size)
         SZ_B:    w_load_ext = {{24{r_sext & w_lane[7]}},  w_lane[7:0]};
         SZ_H:    w_load_ext = {{16{r_sext & w_lane[15]}}, w_lane[15:0]};
         default: w_load_ext = w_lane;
      endcase
   end

   assign w_wait_nxt = r_wait + 8'd1;

   // Control FSM with registered outputs
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state         <= S_IDLE;
         r_wait          <= 8'd0;
         r_is_load       <= 1'b0;
         r_sext          <= 1'b0;
         r_size          <= SZ_B;
         r_addr_lo       <= 2'b00;
         r_addr_err_pend <= 1'b0;
         r_bus_err_pend  <= 1'b0;
         o_busy          <= 1'b0;
         o_done          <= 1'b0;
         o_load_data     <= 32'd0;
         o_addr_err      <= 1'b0;
         o_bus_err       <= 1'b0;
         o_dmem_req      <= 1'b0;
         o_dmem_we       <= 1'b0;
         o_dmem_addr     <= 32'd0;
         o_dmem_be       <= 4'd0;
         o_dmem_wdata    <= 32'd0;
      end else begin
         o_done     <= 1'b0;
         o_addr_err <= 1'b0;
         o_bus_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_is_load       <= w_is_load;
                  r_sext          <= w_sext;
                  r_size          <= w_size;
                  r_addr_lo       <= i_addr[1:0];
                  r_addr_err_pend <= w_misalign && (w_is_load || w_is_store);
                  r_bus_err_pend  <= 1'b0;
                  r_wait          <= 8'd0;
                  o_busy          <= 1'b1;
                  if (w_legal) begin
                     r_state      <= S_ACCESS;
                     o_dmem_req   <= 1'b1;
                     o_dmem_we    <= w_is_store;
                     o_dmem_addr  <= {i_addr[31:2], 2'b00};
                     o_dmem_be    <= w_be;
                     o_dmem_wdata <= w_wdata;
                  end else begin
                     r_state <= S_FINISH;
                  end
               end
            end
            S_ACCESS: begin
               // An ack in the timeout cycle still completes the access cleanly
               if (i_dmem_ack) begin
                  if (r_is_load) o_load_data <= w_load_ext;
                  o_dmem_req <= 1'b0;
                  o_dmem_we  <= 1'b0;
                  r_state    <= S_FINISH;
               end else if (w_wait_nxt == TIMEOUT) begin
                  r_wait         <= w_wait_nxt;
                  r_bus_err_pend <= 1'b1;
                  o_dmem_req     <= 1'b0;
                  o_dmem_we      <= 1'b0;
                  r_state        <= S_FINISH;
               end else begin
                  r_wait <= w_wait_nxt;
               end
            end
            S_FINISH: begin
               o_done     <= 1'b1;
               o_addr_err <= r_addr_err_pend;
               o_bus_err  <= r_bus_err_pend;
               o_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: begin
               o_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, 8'd255, maximum cycles to wait for dmem_ack before a bus error is flagged.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 start  input  1  request strobe; sampled only in IDLE.
REQ-005 mem_op  input  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
REQ-006 addr  input  32  effective byte address (ALU add result).
REQ-007 store_data  input  32  rt value for stores; low byte/half used for SB/SH.
REQ-008 busy  output  1  high whenever state is not IDLE.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 load_data  output  32  extended load result; valid when done=1; holds value until next done.
REQ-011 addr_err  output  1  misalignment flag; valid with done.
REQ-012 bus_err  output  1  timeout flag; valid with done.
REQ-013 dmem_req  output  1  memory request; held high until ack or timeout.
REQ-014 dmem_we  output  1  1 = write.
REQ-015 dmem_addr  output  32  {addr[31:2],2'b00}.
REQ-016 dmem_be  output  4  byte enables; bit i = byte lane i, little-endian.
REQ-017 dmem_wdata  output  32  store data replicated to all lanes (byte x4, half x2, word).
REQ-018 dmem_ack  input  1  memory completion, single-cycle pulse.
REQ-019 dmem_rdata  input  32  read word; valid when dmem_ack=1.

Function
REQ-020 FSM states SHALL be IDLE, ACCESS, FINISH.
REQ-021 IDLE, start=1: the unit SHALL register mem_op, addr and store_data, and SHALL go to ACCESS for a legal aligned load/store, or to FINISH otherwise.
REQ-022 Alignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL set addr_err=1, issue no memory request, and go to FINISH.
REQ-023 NONE/illegal op SHALL go to FINISH with no access and no error flags.
REQ-024 ACCESS: dmem_req=1 with dmem_addr, dmem_we, dmem_be and dmem_wdata stable from the first ACCESS cycle until exit.
REQ-025 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads SHALL drive the same be pattern.
REQ-026 ACCESS, dmem_ack=1: load_data SHALL capture the extracted lane (LB/LH sign-extended, LBU/LHU zero-extended, LW as-is), then go to FINISH.
REQ-027 A wait counter SHALL reset on entry to ACCESS and increment each ACCESS cycle without ack; reaching TIMEOUT SHALL set bus_err=1, drop dmem_req, and go to FINISH.
REQ-028 If ack and the timeout occur in the same cycle, ack SHALL win and bus_err SHALL stay 0.
REQ-029 FINISH SHALL assert done=1 for exactly one cycle, then return to IDLE; addr_err and bus_err SHALL be meaningful only while done=1, and 0 otherwise.
REQ-030 Latency: aligned access with ack on the k-th ACCESS cycle (k>=1) gives done k+1 cycles after the start-sampling edge; misaligned or NONE gives done 1 cycle after.
REQ-031 start while busy=1 SHALL be ignored; dmem_ack outside ACCESS SHALL be ignored.
REQ-032 Back-to-back: start may be sampled in the IDLE cycle immediately after FINISH.
REQ-033 Stores SHALL leave load_data unchanged.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE with the counter 0, and busy, done, addr_err, bus_err, dmem_req and dmem_we all 0; load_data, dmem_addr, dmem_be and dmem_wdata SHALL be 0.
REQ-035 Reset during ACCESS SHALL drop dmem_req on that edge; a later ack SHALL be ignored.

Verification
REQ-036 LB at addr 0x1003, rdata 0x80FF_1234, ack on 2nd ACCESS cycle -> be=4'b1000, load_data=0xFFFF_FF80, done 3 cycles after start.
REQ-037 SH at 0x2002, store_data 0x0000_ABCD -> be=4'b1100, wdata=0xABCD_ABCD, we=1, load_data unchanged.
REQ-038 LW at 0x0000_0006 -> no dmem_req, done+addr_err=1 next cycle; LHU at 0x6 with rdata 0x8001_0000 -> load_data=0x0000_8001.
REQ-039 LW with TIMEOUT=4 and no ack -> req high 4 cycles, then done+bus_err=1, load_data unchanged; ack on the 4th cycle instead -> bus_err=0.
REQ-040 rst_n=0 mid-ACCESS, then ack -> req=0 on the reset edge, no done, busy=0; a start during busy -> ignored.
